// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate type.
package vga_timing_pkg;

   localparam int unsigned CLK_DIV  = 4;
   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam bit          SYNC_POL = 1'b0;

   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-cycle pixel-tick enable.
module pixel_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      div_d = tick ? '0 : div_q + DW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/vga_display_timing.sv
// VGA raster generator: pixel/line counters plus registered sync and visible-area decode.
module vga_display_timing #(
   parameter int unsigned CLK_DIV  = vga_timing_pkg::CLK_DIV,
   parameter int unsigned H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_timing_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_timing_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_timing_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_timing_pkg::V_BP,
   parameter bit          SYNC_POL = vga_timing_pkg::SYNC_POL
) (
   input  logic       clk,
   input  logic       rst,
   output logic       hsync,
   output logic       vsync,
   output logic [9:0] sx,
   output logic [9:0] sy,
   output logic       enable
);

   import vga_timing_pkg::*;

   localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
   localparam coord_t V_VIS    = coord_t'(V_ACTIVE);

   logic   tick;
   coord_t sx_q, sx_d, sy_q, sy_d;
   logic   hsync_q, vsync_q, enable_q;

   pixel_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   always_comb begin
      sx_d = sx_q;
      sy_d = sy_q;
      if (tick) begin
         if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 10'd1;
         end else begin
            sx_d = sx_q + 10'd1;
         end
      end
   end

   // Decode from the next-state counters so outputs line up with the sx/sy they accompany.
   always_ff @(posedge clk) begin
      if (rst) begin
         sx_q     <= '0;
         sy_q     <= '0;
         hsync_q  <= ~SYNC_POL;
         vsync_q  <= ~SYNC_POL;
         enable_q <= 1'b1;
      end else begin
         sx_q     <= sx_d;
         sy_q     <= sy_d;
         hsync_q  <= (sx_d >= HS_START && sx_d <= HS_END) ? SYNC_POL : ~SYNC_POL;
         vsync_q  <= (sy_d >= VS_START && sy_d <= VS_END) ? SYNC_POL : ~SYNC_POL;
         enable_q <= (sx_d < H_VIS) && (sy_d < V_VIS);
      end
   end

   assign sx     = sx_q;
   assign sy     = sy_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign enable = enable_q;

endmodule

// File: tb/tb_vga_display_timing.sv
// Scoreboard bench: full-size raster (A) plus a shrunken raster (B) for frame-level timing.
module tb_vga_display_timing;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, rst_b = 1'b1;
   logic       hs_a, vs_a, en_a, hs_b, vs_b, en_b;
   logic [9:0] sx_a, sy_a, sx_b, sy_b;

   vga_display_timing dut_a (
      .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .sx(sx_a), .sy(sy_a), .enable(en_a)
   );

   // 32x12 raster: sync at sx 20..27 and sy 8..9, 128 clk per line, 1536 clk per frame.
   vga_display_timing #(
      .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
   ) dut_b (
      .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .sx(sx_b), .sy(sy_b), .enable(en_b)
   );

   typedef struct {
      int n;
      int sx;
      int sy;
      int hs;
      int vs;
      int en;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   int   errors = 0;
   int   checks = 0;

   // Clock edges since reset release, per instance.
   int   cnt_a = 0, cnt_b = 0;
   logic rstd_a = 1'b1, rstd_b = 1'b1;

   always @(posedge clk) begin
      cnt_a  <= rst_a ? 0 : cnt_a + 1;
      cnt_b  <= rst_b ? 0 : cnt_b + 1;
      rstd_a <= rst_a;
      rstd_b <= rst_b;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic cmp_exp(input string t, input exp_t e, input logic [9:0] sx, sy,
                          input logic hs, vs, en);
      string p;
      p = $sformatf("%s@%0d", t, e.n);
      check({p, " sx"}, int'(sx), e.sx);
      check({p, " sy"}, int'(sy), e.sy);
      check({p, " hsync"}, int'(hs), e.hs);
      check({p, " vsync"}, int'(vs), e.vs);
      check({p, " enable"}, int'(en), e.en);
   endtask

   task automatic inv(input string t, input int n, input logic rd,
                      input logic [9:0] sx, sy, input logic hs, vs, en,
                      input logic [9:0] psx, psy, input logic phs, pvs, pen,
                      input int ht, vt, ha, va);
      int x, y, px, py;
      x  = int'(sx);
      y  = int'(sy);
      px = int'(psx);
      py = int'(psy);
      if (rd) begin
         check({t, " reset state"}, int'({sx, sy, hs, vs, en}), int'({20'd0, 3'b111}));
      end
      check({t, " enable decode"}, int'(en), int'(x < ha && y < va));
      check({t, " bounds"}, int'(x < ht && y < vt), 1);
      if (!rd && n > 0) begin
         if (n % 4 != 0) begin
            check({t, " hold"}, int'({sx, sy, hs, vs, en}), int'({psx, psy, phs, pvs, pen}));
         end else begin
            check({t, " sx step"}, x, (px + 1) % ht);
            check({t, " sy step"}, y, (px == ht - 1) ? (py + 1) % vt : py);
         end
      end
   endtask

   logic [9:0] psx_a, psy_a, psx_b, psy_b;
   logic       phs_a, pvs_a, pen_a, phs_b, pvs_b, pen_b;
   int         hfall_a = -1, hfall_b = -1, vfall_b = -1;

   always @(negedge clk) begin
      if (q_a.size() > 0 && q_a[0].n == cnt_a) begin
         cmp_exp("A", q_a[0], sx_a, sy_a, hs_a, vs_a, en_a);
         q_a.delete(0);
      end
      inv("A", cnt_a, rstd_a, sx_a, sy_a, hs_a, vs_a, en_a,
          psx_a, psy_a, phs_a, pvs_a, pen_a, 800, 525, 640, 480);
      if (rstd_a) begin
         hfall_a <= -1;
      end else begin
         if (phs_a && !hs_a) begin
            if (hfall_a >= 0) check("A line period", cnt_a - hfall_a, 3200);
            hfall_a <= cnt_a;
         end
         if (!phs_a && hs_a && hfall_a >= 0) check("A hsync low clk", cnt_a - hfall_a, 384);
      end
      psx_a <= sx_a; psy_a <= sy_a; phs_a <= hs_a; pvs_a <= vs_a; pen_a <= en_a;
   end

   always @(negedge clk) begin
      if (q_b.size() > 0 && q_b[0].n == cnt_b) begin
         cmp_exp("B", q_b[0], sx_b, sy_b, hs_b, vs_b, en_b);
         q_b.delete(0);
      end
      inv("B", cnt_b, rstd_b, sx_b, sy_b, hs_b, vs_b, en_b,
          psx_b, psy_b, phs_b, pvs_b, pen_b, 32, 12, 16, 6);
      if (rstd_b) begin
         hfall_b <= -1;
         vfall_b <= -1;
      end else begin
         if (phs_b && !hs_b) begin
            if (hfall_b >= 0) check("B line period", cnt_b - hfall_b, 128);
            hfall_b <= cnt_b;
         end
         if (!phs_b && hs_b && hfall_b >= 0) check("B hsync low clk", cnt_b - hfall_b, 32);
         if (pvs_b && !vs_b) begin
            if (vfall_b >= 0) check("B frame period", cnt_b - vfall_b, 1536);
            vfall_b <= cnt_b;
         end
         if (!pvs_b && vs_b && vfall_b >= 0) check("B vsync low clk", cnt_b - vfall_b, 256);
      end
      psx_b <= sx_b; psy_b <= sy_b; phs_b <= hs_b; pvs_b <= vs_b; pen_b <= en_b;
   end

   task automatic push_a(input int n, sx, sy, hs, vs, en);
      exp_t e;
      e = '{n: n, sx: sx, sy: sy, hs: hs, vs: vs, en: en};
      q_a.push_back(e);
   endtask

   task automatic push_b(input int n, sx, sy, hs, vs, en);
      exp_t e;
      e = '{n: n, sx: sx, sy: sy, hs: hs, vs: vs, en: en};
      q_b.push_back(e);
   endtask

   task automatic run_a();
      push_a(0, 0, 0, 1, 1, 1);
      repeat (30) @(negedge clk);
      rst_a = 1'b0;
      push_a(3, 0, 0, 1, 1, 1);
      push_a(4, 1, 0, 1, 1, 1);
      push_a(8, 2, 0, 1, 1, 1);
      push_a(2559, 639, 0, 1, 1, 1);
      push_a(2560, 640, 0, 1, 1, 0);
      push_a(2623, 655, 0, 1, 1, 0);
      push_a(2624, 656, 0, 0, 1, 0);
      push_a(3007, 751, 0, 0, 1, 0);
      push_a(3008, 752, 0, 1, 1, 0);
      push_a(3199, 799, 0, 1, 1, 0);
      push_a(3200, 0, 1, 1, 1, 1);
      push_a(8960, 640, 2, 1, 1, 0);
      push_a(9600, 0, 3, 1, 1, 1);
      push_a(10800, 300, 3, 1, 1, 1);
      for (int i = 0; i < 20000 && cnt_a != 10800; i++) @(negedge clk);
      check("A reach mid-line", cnt_a, 10800);
      // One-cycle reset mid-line must restart the raster at (0,0).
      push_a(0, 0, 0, 1, 1, 1);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      push_a(3, 0, 0, 1, 1, 1);
      push_a(4, 1, 0, 1, 1, 1);
      push_a(3199, 799, 0, 1, 1, 0);
      push_a(3200, 0, 1, 1, 1, 1);
      for (int i = 0; i < 20000 && q_a.size() > 0; i++) @(negedge clk);
      check("A scoreboard drained", q_a.size(), 0);
   endtask

   task automatic run_b();
      push_b(0, 0, 0, 1, 1, 1);
      repeat (30) @(negedge clk);
      rst_b = 1'b0;
      push_b(4, 1, 0, 1, 1, 1);
      push_b(80, 20, 0, 0, 1, 0);
      push_b(111, 27, 0, 0, 1, 0);
      push_b(112, 28, 0, 1, 1, 0);
      push_b(703, 15, 5, 1, 1, 1);
      push_b(704, 16, 5, 1, 1, 0);
      push_b(768, 0, 6, 1, 1, 0);
      push_b(1023, 31, 7, 1, 1, 0);
      push_b(1024, 0, 8, 1, 0, 0);
      push_b(1279, 31, 9, 1, 0, 0);
      push_b(1280, 0, 10, 1, 1, 0);
      push_b(1535, 31, 11, 1, 1, 0);
      push_b(1536, 0, 0, 1, 1, 1);
      push_b(3624, 10, 4, 1, 1, 1);
      for (int i = 0; i < 20000 && cnt_b != 3624; i++) @(negedge clk);
      check("B reach mid-frame", cnt_b, 3624);
      push_b(0, 0, 0, 1, 1, 1);
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      push_b(4, 1, 0, 1, 1, 1);
      push_b(128, 0, 1, 1, 1, 1);
      for (int i = 0; i < 20000 && q_b.size() > 0; i++) @(negedge clk);
      check("B scoreboard drained", q_b.size(), 0);
   endtask

   initial begin
      fork
         run_a();
         run_b();
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
